// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan driver.
// Glyphs are active-low, segment a on bit 0 through segment g on bit 6.
// Also holds the leading-zero blanking rule used when choosing a digit's slot.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Index 0..F -> active-low glyph (gfedcba)
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // A digit is blanked when blanking is enabled, it is not the rightmost
  // digit, and it plus every more-significant nibble are all zero.
  function automatic logic digit_blanked(input logic [15:0] value,
                                         input digit_idx_t idx,
                                         input logic blz);
    logic [15:0] upper;
    upper = value >> {idx, 2'b00};
    return blz && (idx != 2'd0) && (upper == 16'h0000);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side load bus of the scan driver: value, decimal points, blanking mode,
// a single-cycle load strobe and the acknowledge returned when the value
// reaches the display.
interface seg7_scan_driver_if;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        load_ack;

  modport master (output data_in, dp_in, load, blank_lz, input load_ack);
  modport slave  (input data_in, dp_in, load, blank_lz, output load_ack);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low seven-segment glyph.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex display driver with frame-aligned updates.
// Latency: a load reaches the display at the next frame boundary (3->0 tick).
// Backpressure: none; a newer load overwrites an unapplied pending one.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_CLKS = 200_000,
  parameter int CNT_W        = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  host,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp,
  output digit_idx_t         digit_sel
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CLKS - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             frame;
  digit_idx_t       next_sel;

  logic [15:0] pend_data;
  logic [3:0]  pend_dp;
  logic        pend_blz;
  logic        pend_vld;

  logic [15:0] disp_data;
  logic [3:0]  disp_dp;
  logic        disp_blz;

  logic        apply_new;
  logic        apply_pend;
  logic        apply;
  logic [15:0] eff_data;
  logic [3:0]  eff_dp;
  logic        eff_blz;
  logic [3:0]  sel_nibble;
  logic [6:0]  glyph;
  logic        blanked;

  assign tick     = (cnt == CNT_LAST);
  assign next_sel = digit_sel + 2'd1;
  assign frame    = tick && (digit_sel == 2'd3);

  // A load landing on the boundary tick bypasses the pending register.
  assign apply_new  = frame && host.load;
  assign apply_pend = frame && !host.load && pend_vld;
  assign apply      = apply_new || apply_pend;

  // Value used for the digit about to be driven: on a boundary edge this is
  // the incoming value so digit 0 of the new frame already shows it.
  always_comb begin
    eff_data = disp_data;
    eff_dp   = disp_dp;
    eff_blz  = disp_blz;
    if (apply_new) begin
      eff_data = host.data_in;
      eff_dp   = host.dp_in;
      eff_blz  = host.blank_lz;
    end else if (apply_pend) begin
      eff_data = pend_data;
      eff_dp   = pend_dp;
      eff_blz  = pend_blz;
    end
  end

  // Select the nibble of the digit that becomes active on the next tick.
  always_comb begin
    sel_nibble = eff_data[3:0];
    case (next_sel)
      2'd0:    sel_nibble = eff_data[3:0];
      2'd1:    sel_nibble = eff_data[7:4];
      2'd2:    sel_nibble = eff_data[11:8];
      default: sel_nibble = eff_data[15:12];
    endcase
  end

  assign blanked = digit_blanked(eff_data, next_sel, eff_blz);

  seg7_hex_decoder u_dec (
    .nibble (sel_nibble),
    .glyph  (glyph)
  );

  // Refresh counter: 0..REFRESH_CLKS-1 then wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending capture, frame-boundary transfer to the display register and ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data     <= '0;
      pend_dp       <= '0;
      pend_blz      <= 1'b0;
      pend_vld      <= 1'b0;
      disp_data     <= '0;
      disp_dp       <= '0;
      disp_blz      <= 1'b0;
      host.load_ack <= 1'b0;
    end else begin
      host.load_ack <= apply;
      if (apply) begin
        disp_data <= eff_data;
        disp_dp   <= eff_dp;
        disp_blz  <= eff_blz;
        pend_vld  <= 1'b0;
      end else if (host.load) begin
        pend_data <= host.data_in;
        pend_dp   <= host.dp_in;
        pend_blz  <= host.blank_lz;
        pend_vld  <= 1'b1;
      end
    end
  end

  // Registered digit outputs, updated only on refresh ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
      digit_sel <= 2'd3;
    end else if (tick) begin
      digit_sel <= next_sel;
      if (blanked) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << next_sel);
        seg <= glyph;
        dp  <= ~eff_dp[next_sel];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a 4-clock refresh period.
// Reference model counts clock edges since reset to locate ticks and frames.
// Directed scenarios followed by random loads; every cycle is compared.
module tb_seg7_scan_driver;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_sel;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.REFRESH_CLKS(R), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (bus),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_seen = 0;

  logic [6:0] glyph_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model state
  int          e;
  logic [15:0] d_val, p_val;
  logic [3:0]  d_dp, p_dp;
  logic        d_blz, p_blz, p_vld;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [1:0]  exp_sel;
  logic        exp_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    e = 0;
    d_val = '0; d_dp = '0; d_blz = 1'b0;
    p_val = '0; p_dp = '0; p_blz = 1'b0; p_vld = 1'b0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_sel = 2'd3; exp_ack = 1'b0;
  endtask

  // One clock edge of the reference: every R-th edge after reset is a tick,
  // the tick that selects digit 0 is a frame boundary.
  task automatic model_edge();
    int m, s;
    logic is_tick, is_frame;
    logic [3:0] nib;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e++;
    is_tick  = (e % R) == 0;
    m        = e / R;
    s        = is_tick ? (m - 1) % 4 : 0;
    is_frame = is_tick && (s == 0);
    exp_ack  = 1'b0;
    if (is_frame && bus.load) begin
      d_val = bus.data_in; d_dp = bus.dp_in; d_blz = bus.blank_lz;
      p_vld = 1'b0; exp_ack = 1'b1;
    end else if (is_frame && p_vld) begin
      d_val = p_val; d_dp = p_dp; d_blz = p_blz;
      p_vld = 1'b0; exp_ack = 1'b1;
    end else if (bus.load) begin
      p_val = bus.data_in; p_dp = bus.dp_in; p_blz = bus.blank_lz; p_vld = 1'b1;
    end
    if (is_tick) begin
      exp_sel = 2'(s);
      if (d_blz && s != 0 && (d_val >> (4 * s)) == 16'h0) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        nib     = 4'((d_val >> (4 * s)) & 16'hF);
        exp_an  = 4'hF & ~(4'b0001 << s);
        exp_seg = glyph_ref[nib];
        exp_dp  = ~d_dp[s];
      end
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, "_an"},  32'(an), 32'(exp_an));
    check({where, "_seg"}, 32'(seg), 32'(exp_seg));
    check({where, "_dp"},  32'(dp), 32'(exp_dp));
    check({where, "_sel"}, 32'(digit_sel), 32'(exp_sel));
    check({where, "_ack"}, 32'(bus.load_ack), 32'(exp_ack));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("cyc");
    if (bus.load_ack === 1'b1) ack_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic b);
    bus.data_in = v; bus.dp_in = d; bus.blank_lz = b; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  // Advance until the edge count sits at the given phase of a 16-clock frame.
  task automatic wait_phase(input int ph);
    int k = 0;
    while ((e % (4 * R)) != ph && k < 64) begin
      cyc();
      k++;
    end
    check("phase_reach", 32'(e % (4 * R)), 32'(ph));
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.data_in = '0; bus.dp_in = '0; bus.blank_lz = 1'b0; bus.load = 1'b0;
    model_reset();
    #2;
    assert_reset();

    // Idle scan after reset: digits cycle showing '0', no ack.
    ack_seen = 0;
    run(20);
    check("idle_ack_count", 32'(ack_seen), 32'd0);

    // Mid-frame load of 12AF with dp on digit 2.
    wait_phase(9);
    ack_seen = 0;
    pulse_load(16'h12AF, 4'b0100, 1'b0);
    wait_phase(5);
    check("f_digit0_an", 32'(an), 32'(4'b1110));
    check("f_digit0_seg", 32'(seg), 32'(7'b0001110));
    wait_phase(13);
    check("f_digit2_dp", 32'(dp), 32'd0);
    check("f_digit2_seg", 32'(seg), 32'(7'b0100100));
    check("f_ack_count", 32'(ack_seen), 32'd1);

    // Two loads in one frame: newest wins, one ack.
    wait_phase(6);
    ack_seen = 0;
    pulse_load(16'h1111, 4'b0000, 1'b0);
    run(2);
    pulse_load(16'h2222, 4'b0000, 1'b0);
    wait_phase(5);
    check("two_ld_seg", 32'(seg), 32'(7'b0100100));
    check("two_ld_ack_count", 32'(ack_seen), 32'd1);

    // Leading-zero blanking of 0050.
    wait_phase(8);
    pulse_load(16'h0050, 4'b0000, 1'b1);
    wait_phase(5);
    check("lz_d0_seg", 32'(seg), 32'(7'b1000000));
    wait_phase(9);
    check("lz_d1_seg", 32'(seg), 32'(7'b0010010));
    wait_phase(13);
    check("lz_d2_an", 32'(an), 32'(4'b1111));
    wait_phase(1);
    check("lz_d3_an", 32'(an), 32'(4'b1111));
    check("lz_d3_seg", 32'(seg), 32'(7'b1111111));

    // Load coincident with the frame-boundary tick.
    wait_phase(3);
    pulse_load(16'h0007, 4'b0001, 1'b0);
    check("byp_d0_an", 32'(an), 32'(4'b1110));
    check("byp_d0_seg", 32'(seg), 32'(7'b1111000));
    check("byp_d0_dp", 32'(dp), 32'd0);
    check("byp_ack", 32'(bus.load_ack), 32'd1);
    cyc();
    check("byp_ack_drop", 32'(bus.load_ack), 32'd0);

    // Random loads checked every cycle against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0)
        pulse_load(16'($urandom), 4'($urandom), 1'($urandom));
      else
        cyc();
    end

    // Reset with a pending value mid-frame discards it.
    wait_phase(10);
    pulse_load(16'hBEEF, 4'b1111, 1'b0);
    run(2);
    ack_seen = 0;
    assert_reset();
    run(40);
    check("rst_pend_ack_count", 32'(ack_seen), 32'd0);
    wait_phase(9);
    check("rst_disp_zero_seg", 32'(seg), 32'(7'b1000000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
